// File: rtl/aes_encrypt_pipe_if.sv
// Handshake bundle between the batcher, the AES engine and the serializer.
// The master side drives blocks in and accepts results; the slave side is the engine.
interface aes_encrypt_pipe_if #(
    parameter int TAG_W = 8
);
    logic [127:0]     key;
    logic [127:0]     plaintext;
    logic [TAG_W-1:0] tag_in;
    logic             start;
    logic             ready;
    logic [127:0]     ciphertext;
    logic [TAG_W-1:0] tag_out;
    logic             done;
    logic             out_ready;

    modport master (
        output key, plaintext, tag_in, start, out_ready,
        input  ready, ciphertext, tag_out, done
    );

    modport slave (
        input  key, plaintext, tag_in, start, out_ready,
        output ready, ciphertext, tag_out, done
    );
endinterface

// File: rtl/aes_encrypt_pipe.sv
// Iterative AES-128 ECB encryptor: UNROLL rounds per clock, one block in flight,
// tagged results queued in a small output FIFO until the serializer takes them.
module aes_encrypt_pipe #(
    parameter int UNROLL    = 1,
    parameter int OUT_DEPTH = 2,
    parameter int TAG_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    aes_encrypt_pipe_if.slave bus
);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_encrypt_pipe: UNROLL must be 1, 2, 5 or 10");
    end
    if (OUT_DEPTH < 1) begin : g_bad_depth
        $error("aes_encrypt_pipe: OUT_DEPTH must be at least 1");
    end

    typedef enum logic {S_IDLE, S_ROUNDS} state_e;
    typedef logic [10:0][127:0] rk_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // State byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0]    o;
        logic [3:0][7:0] a;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                      ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic rk_t key_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rk_t         rk_o;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = {SBOX[t[23:16]] ^ rcon, SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk_o;
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       round_cnt_q, round_cnt_d;
    logic [127:0]     key_q, key_d, data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [127:0]     fifo_ct_q  [OUT_DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    rk_t              rk;
    logic [127:0]     chain;
    logic [4:0]       rnd;
    logic             last_step, accept, push, pop, ready, done;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rk        = key_expand(key_q);
    assign ready     = (state_q == S_IDLE) && (count_q < CNT_W'(OUT_DEPTH));
    assign done      = (count_q != '0);
    assign accept    = bus.start && ready;
    assign pop       = done && bus.out_ready;
    assign last_step = (5'(round_cnt_q) + 5'(UNROLL - 1)) == 5'd10;

    always_comb begin
        chain = data_q;
        rnd   = 5'(round_cnt_q);
        for (int u = 0; u < UNROLL; u++) begin
            chain = sub_shift(chain);
            if (rnd != 5'd10) chain = mix_columns(chain);
            chain = chain ^ rk[(rnd > 5'd10) ? 4'd10 : rnd[3:0]];
            rnd   = rnd + 5'd1;
        end
    end

    always_comb begin
        // NOTE: defaults first, so every branch leaves each variable assigned and no latch is inferred.
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        key_d       = key_q;
        tag_d       = tag_q;
        data_d      = data_q;
        push        = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                key_d       = bus.key;
                tag_d       = bus.tag_in;
                data_d      = bus.plaintext ^ bus.key;  // rk0 is the key itself
                round_cnt_d = 4'd1;
                state_d     = S_ROUNDS;
            end
            S_ROUNDS: begin
                data_d      = chain;
                round_cnt_d = round_cnt_q + 4'(UNROLL);
                if (last_step) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            round_cnt_q <= '0;
            key_q       <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            key_q       <= key_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: the queue storage is cleared on reset as well, so discarded blocks leave no residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_ct_q[i]  <= '0;
                fifo_tag_q[i] <= '0;
            end
        end else if (push) begin
            fifo_ct_q[wr_ptr_q]  <= chain;
            fifo_tag_q[wr_ptr_q] <= tag_q;
        end
    end

    assign bus.ready      = ready;
    assign bus.done       = done;
    assign bus.ciphertext = done ? fifo_ct_q[rd_ptr_q]  : '0;
    assign bus.tag_out    = done ? fifo_tag_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_aes_encrypt_pipe.sv
// Self-checking bench: several engine configurations share one stimulus bus and are
// checked against a byte-level software AES model and scenario-specific expectations.
module tb_aes_encrypt_pipe;
    localparam int NI = 5;
    localparam int UNR [NI] = '{1, 2, 5, 10, 1};
    localparam int DEP [NI] = '{2, 2, 2, 2, 3};

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [127:0] key, pt;
    logic [7:0]   tag_in;
    logic         start, out_ready;

    logic [NI-1:0]        ready_v, done_v;
    logic [NI-1:0][127:0] ct_v;
    logic [NI-1:0][7:0]   tag_v;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_encrypt_pipe_if #(.TAG_W(8)) bus_if ();
        assign bus_if.key       = key;
        assign bus_if.plaintext = pt;
        assign bus_if.tag_in    = tag_in;
        assign bus_if.start     = start;
        assign bus_if.out_ready = out_ready;
        assign ready_v[g]       = bus_if.ready;
        assign done_v[g]        = bus_if.done;
        assign ct_v[g]          = bus_if.ciphertext;
        assign tag_v[g]         = bus_if.tag_out;

        aes_encrypt_pipe #(.UNROLL(UNR[g]), .OUT_DEPTH(DEP[g]), .TAG_W(8)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus_if.slave)
        );
    end

    // ---------------- reference model (byte arrays, GF(2^8) arithmetic) ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   w [176];
        logic [7:0]   t [4];
        logic [7:0]   rc, u0;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            st[i] = p[127-8*i -: 8];
            w[i]  = k[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-4+j];
            if (i % 16 == 0) begin
                u0   = t[0];
                t[0] = sbox_m[t[1]] ^ rc;
                t[1] = sbox_m[t[2]];
                t[2] = sbox_m[t[3]];
                t[3] = sbox_m[u0];
                rc   = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbox_m[st[(i + 4*(i%4)) % 16]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    st[4*c+j] = (r == 10) ? tmp[4*c+j] :
                                gmul(8'h02, tmp[4*c+j]) ^ gmul(8'h03, tmp[4*c+(j+1)%4])
                                ^ tmp[4*c+(j+2)%4] ^ tmp[4*c+(j+3)%4];
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_model();
        logic [127:0] got;
        got = aes_model(KEY_A, PT_A);
        checks++;
        if (got !== CT_A) begin
            errors++;
            $display("FAIL model_vector_a: got %h expected %h", got, CT_A);
        end
        got = aes_model(KEY_B, PT_B);
        checks++;
        if (got !== CT_B) begin
            errors++;
            $display("FAIL model_vector_b: got %h expected %h", got, CT_B);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (ready_v[g] !== 1'b1 || done_v[g] !== 1'b0 || ct_v[g] !== '0 || tag_v[g] !== '0) begin
                errors++;
                $display("FAIL reset_during[%0d]: ready=%b done=%b ct=%h tag=%h, expected 1 0 0 0",
                         g, ready_v[g], done_v[g], ct_v[g], tag_v[g]);
            end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (ready_v[g] !== 1'b1 || done_v[g] !== 1'b0 || ct_v[g] !== '0 || tag_v[g] !== '0) begin
                errors++;
                $display("FAIL reset_after[%0d]: ready=%b done=%b ct=%h tag=%h, expected 1 0 0 0",
                         g, ready_v[g], done_v[g], ct_v[g], tag_v[g]);
            end
        end
    endtask

    // Accept one block on every instance, scramble the inputs each following cycle,
    // and measure accept-to-done latency and the result per instance.
    task automatic test_fips(input logic [127:0] k, input logic [127:0] p,
                             input logic [7:0] tg, input logic [127:0] exp_ct);
        int         lat [NI];
        bit         drop_bad [NI];
        logic [127:0] got_ct [NI];
        logic [7:0] got_tag [NI];
        for (int g = 0; g < NI; g++) begin
            lat[g] = -1;
            drop_bad[g] = 1'b0;
            got_ct[g] = '0;
            got_tag[g] = '0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        key = k;
        pt = p;
        tag_in = tg;
        start = 1'b1;
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (ready_v[g] !== 1'b1 || done_v[g] !== 1'b0) begin
                errors++;
                $display("FAIL fips_pre_accept[%0d]: ready=%b done=%b, expected ready=1 done=0",
                         g, ready_v[g], done_v[g]);
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            key = rand128();
            pt = rand128();
            tag_in = 8'($urandom);
            @(posedge clk);
            #1;
            for (int g = 0; g < NI; g++) begin
                if (lat[g] < 0 && done_v[g] === 1'b1) begin
                    lat[g] = cyc;
                    got_ct[g] = ct_v[g];
                    got_tag[g] = tag_v[g];
                end else if (lat[g] >= 0 && cyc == lat[g] + 1 && done_v[g] !== 1'b0) begin
                    drop_bad[g] = 1'b1;
                end
            end
        end
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (lat[g] != 10 / UNR[g]) begin
                errors++;
                $display("FAIL fips_latency[%0d]: got %0d expected %0d", g, lat[g], 10 / UNR[g]);
            end
            checks++;
            if (got_ct[g] !== exp_ct || got_tag[g] !== tg) begin
                errors++;
                $display("FAIL fips_result[%0d]: got %h/%h expected %h/%h", g, got_ct[g], got_tag[g], exp_ct, tg);
            end
            checks++;
            if (drop_bad[g]) begin
                errors++;
                $display("FAIL fips_done_drop[%0d]: done still 1 after pop, expected 0", g);
            end
        end
    endtask

    // Instance 0 (depth 2): three blocks offered with start held high and the sink stalled.
    task automatic test_backpressure();
        logic [127:0] bk [3];
        logic [127:0] bp [3];
        logic [127:0] exp_ct [3];
        int nacc, npop, pop_cyc, acc3_cyc;
        bit acc, rdy_at_pop;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            bk[i] = rand128();
            bp[i] = rand128();
            exp_ct[i] = aes_model(bk[i], bp[i]);
        end
        nacc = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            start = (nacc < 3);
            key = bk[(nacc < 3) ? nacc : 2];
            pt = bp[(nacc < 3) ? nacc : 2];
            tag_in = 8'((nacc < 3) ? nacc + 1 : 3);
            acc = start && ready_v[0];
            @(posedge clk);
            if (acc) nacc++;
        end
        @(negedge clk);
        checks++;
        if (nacc != 2 || ready_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: accepted=%0d ready=%b, expected accepted=2 ready=0", nacc, ready_v[0]);
        end
        checks++;
        if (done_v[0] !== 1'b1 || tag_v[0] !== 8'd1 || ct_v[0] !== exp_ct[0]) begin
            errors++;
            $display("FAIL bp_head: done=%b tag=%h ct=%h, expected 1/01/%h", done_v[0], tag_v[0], ct_v[0], exp_ct[0]);
        end
        npop = 0;
        pop_cyc = -1;
        acc3_cyc = -1;
        rdy_at_pop = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = 1'b1;
            start = (nacc < 3);
            key = bk[(nacc < 3) ? nacc : 2];
            pt = bp[(nacc < 3) ? nacc : 2];
            tag_in = 8'((nacc < 3) ? nacc + 1 : 3);
            acc = start && ready_v[0];
            if (done_v[0]) begin
                checks++;
                if (npop >= 3) begin
                    errors++;
                    $display("FAIL bp_extra_pop: got tag %h, expected no further block", tag_v[0]);
                end else if (ct_v[0] !== exp_ct[npop] || tag_v[0] !== 8'(npop + 1)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h/%h expected %h/%h",
                             npop, ct_v[0], tag_v[0], exp_ct[npop], 8'(npop + 1));
                end
                if (npop == 0) begin
                    pop_cyc = cyc;
                    rdy_at_pop = ready_v[0];
                end
                npop++;
            end
            if (acc) begin
                if (nacc == 2) acc3_cyc = cyc;
                nacc++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (rdy_at_pop !== 1'b0 || acc3_cyc != pop_cyc + 1) begin
            errors++;
            $display("FAIL bp_slot_free: ready at pop=%b, tag3 accept cycle %0d, expected ready=0 and cycle %0d",
                     rdy_at_pop, acc3_cyc, pop_cyc + 1);
        end
        checks++;
        if (npop != 3) begin
            errors++;
            $display("FAIL bp_pop_count: got %0d expected 3", npop);
        end
    endtask

    // Reset asserted while round 5 of a second block computes, with one block queued.
    task automatic test_reset_midround();
        apply_reset();
        @(negedge clk);
        key = rand128();
        pt = rand128();
        tag_in = 8'hA1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (done_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_queued: done=%b expected 1", done_v[0]);
        end
        key = rand128();
        pt = rand128();
        tag_in = 8'hB2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (done_v[0] !== 1'b0 || ct_v[0] !== '0 || tag_v[0] !== '0 || ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_immediate: done=%b ct=%h tag=%h ready=%b, expected 0 0 0 1",
                     done_v[0], ct_v[0], tag_v[0], ready_v[0]);
        end
        @(negedge clk);
        checks++;
        if (done_v[0] !== 1'b0 || ct_v[0] !== '0 || ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_held: done=%b ct=%h ready=%b, expected 0 0 1", done_v[0], ct_v[0], ready_v[0]);
        end
        reset = 1'b1;
        test_fips(KEY_A, PT_A, 8'h5A, CT_A);
    endtask

    // Instance 4 (UNROLL=1, depth 3): random traffic against a FIFO of model results.
    task automatic test_random();
        logic [135:0] expq [$];
        logic [135:0] exp_e;
        logic [127:0] hold_ct;
        logic [7:0]   hold_tag;
        bit hold, fast;
        int sent, recv;
        apply_reset();
        sent = 0;
        recv = 0;
        hold = 1'b0;
        hold_ct = '0;
        hold_tag = '0;
        for (int cyc = 0; cyc < 60000 && recv < 1000; cyc++) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if (done_v[4] !== 1'b1 || ct_v[4] !== hold_ct || tag_v[4] !== hold_tag) begin
                    errors++;
                    $display("FAIL rand_stable: done=%b ct=%h tag=%h expected 1/%h/%h",
                             done_v[4], ct_v[4], tag_v[4], hold_ct, hold_tag);
                end
            end
            fast = ((cyc / 200) % 2) == 0;
            out_ready = fast ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0);
            start = (sent < 1000) && ($urandom_range(0, 3) != 0);
            key = rand128();
            pt = rand128();
            tag_in = 8'($urandom);
            if (start && ready_v[4]) begin
                expq.push_back({aes_model(key, pt), tag_in});
                sent++;
            end
            if (done_v[4] && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: got %h/%h with nothing outstanding", ct_v[4], tag_v[4]);
                end else begin
                    exp_e = expq.pop_front();
                    if ({ct_v[4], tag_v[4]} !== exp_e) begin
                        errors++;
                        $display("FAIL rand_data[%0d]: got %h/%h expected %h/%h",
                                 recv, ct_v[4], tag_v[4], exp_e[135:8], exp_e[7:0]);
                    end
                end
                recv++;
            end
            hold = done_v[4] && !out_ready;
            hold_ct = ct_v[4];
            hold_tag = tag_v[4];
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (sent != 1000 || recv != 1000 || expq.size() != 0 || done_v[4] !== 1'b0) begin
            errors++;
            $display("FAIL rand_totals: sent=%0d recv=%0d left=%0d done=%b, expected 1000 1000 0 0",
                     sent, recv, expq.size(), done_v[4]);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        key = '0;
        pt = '0;
        tag_in = '0;
        build_sbox();
        test_model();
        test_reset();
        test_fips(KEY_A, PT_A, 8'h5A, CT_A);
        test_fips(KEY_B, PT_B, 8'hC3, CT_B);
        test_backpressure();
        test_reset_midround();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
